// File: rtl/tetris_board_reg.sv
// Tetris playfield register file: whole-board load, single-row write and a
// self-timed line clear that removes full rows and drops everything above.
//
// state | meaning
// IDLE  | accept LoadAll / LoadRow / ClearStart (that priority)
// SCAN  | test row idx for fullness, walking bottom to top
// SHIFT | rows 1..idx take rows 0..idx-1, an empty row enters at the top
// DONE  | one-cycle completion pulse, LinesCleared valid
module tetris_board_reg #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int PIX_W = 4,
    parameter int CNT_W = $clog2(ROWS + 1)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        LoadAll,
    input  logic [ROWS*COLS*PIX_W-1:0]  PixelMapIn,
    input  logic                        LoadRow,
    input  logic [$clog2(ROWS)-1:0]     RowSel,
    input  logic [COLS*PIX_W-1:0]       RowIn,
    input  logic                        ClearStart,
    output logic                        Busy,
    output logic                        Done,
    output logic [CNT_W-1:0]            LinesCleared,
    output logic [ROWS-1:0]             RowFull,
    output logic [ROWS*COLS*PIX_W-1:0]  BoardOut
);

    localparam int ROW_W = COLS * PIX_W;
    localparam int BRD_W = ROWS * ROW_W;
    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] lines_q, lines_d;
    logic [BRD_W-1:0] board_q, board_d;
    logic [ROWS-1:0]  row_full;

    always_comb begin
        row_full = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (board_q[r*ROW_W + c*PIX_W +: PIX_W] == '0) begin
                    row_full[r] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lines_d = lines_q;
        board_d = board_q;
        case (state_q)
            S_IDLE: begin
                if (LoadAll) begin
                    board_d = PixelMapIn;
                end else if (LoadRow) begin
                    // Out-of-range RowSel matches no row and is silently a no-op.
                    for (int r = 0; r < ROWS; r++) begin
                        if (int'(RowSel) == r) begin
                            board_d[r*ROW_W +: ROW_W] = RowIn;
                        end
                    end
                end else if (ClearStart) begin
                    state_d = S_SCAN;
                    idx_d   = IDX_LAST;
                    lines_d = '0;
                end
            end
            S_SCAN: begin
                if (row_full[idx_q]) begin
                    state_d = S_SHIFT;
                    lines_d = lines_q + CNT_W'(1);
                end else if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_SHIFT: begin
                // idx is kept so the row that just dropped in is scanned again.
                for (int r = 1; r < ROWS; r++) begin
                    if (r <= int'(idx_q)) begin
                        board_d[r*ROW_W +: ROW_W] = board_q[(r-1)*ROW_W +: ROW_W];
                    end
                end
                board_d[ROW_W-1:0] = '0;
                state_d = S_SCAN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_LAST;
            lines_q <= '0;
            board_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lines_q <= lines_d;
            board_q <= board_d;
        end
    end

    assign Busy         = (state_q == S_SCAN) || (state_q == S_SHIFT);
    assign Done         = (state_q == S_DONE);
    assign LinesCleared = lines_q;
    assign RowFull      = row_full;
    assign BoardOut     = board_q;

endmodule

// File: tb/tb_tetris_board_reg.sv
// Bench for tetris_board_reg: directed and random scenarios against a
// row-list model (full rows filtered out, survivors stacked at the bottom).
module tb_tetris_board_reg;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int PIX_W = 4;
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int IDX_W = $clog2(ROWS);
    localparam int RW    = COLS * PIX_W;
    localparam int BW    = ROWS * RW;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              LoadAll = 1'b0;
    logic [BW-1:0]     PixelMapIn = '0;
    logic              LoadRow = 1'b0;
    logic [IDX_W-1:0]  RowSel = '0;
    logic [RW-1:0]     RowIn = '0;
    logic              ClearStart = 1'b0;
    logic              Busy;
    logic              Done;
    logic [CNT_W-1:0]  LinesCleared;
    logic [ROWS-1:0]   RowFull;
    logic [BW-1:0]     BoardOut;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] m_rows [ROWS];
    int            m_lines;

    always #5 Clk = ~Clk;

    tetris_board_reg #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .LoadAll(LoadAll), .PixelMapIn(PixelMapIn),
        .LoadRow(LoadRow), .RowSel(RowSel), .RowIn(RowIn), .ClearStart(ClearStart),
        .Busy(Busy), .Done(Done), .LinesCleared(LinesCleared), .RowFull(RowFull),
        .BoardOut(BoardOut)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit full_row(input logic [RW-1:0] row);
        for (int c = 0; c < COLS; c++) begin
            if (row[c*PIX_W +: PIX_W] == '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [BW-1:0] m_flat();
        logic [BW-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r*RW +: RW] = m_rows[r];
        return f;
    endfunction

    function automatic logic [ROWS-1:0] m_full();
        logic [ROWS-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r] = full_row(m_rows[r]);
        return f;
    endfunction

    function automatic logic [RW-1:0] fill_row(input logic [PIX_W-1:0] v);
        logic [RW-1:0] row;
        for (int c = 0; c < COLS; c++) row[c*PIX_W +: PIX_W] = v;
        return row;
    endfunction

    // kind 0: empty, 1: full, otherwise sparse random
    function automatic logic [RW-1:0] rand_row(input int kind);
        logic [RW-1:0] row;
        row = '0;
        for (int c = 0; c < COLS; c++) begin
            if (kind == 1)
                row[c*PIX_W +: PIX_W] = PIX_W'($urandom_range(1, 15));
            else if (kind != 0 && $urandom_range(0, 3) != 0)
                row[c*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 15));
        end
        return row;
    endfunction

    task automatic m_clear_rows();
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    endtask

    task automatic m_random_board();
        for (int r = 0; r < ROWS; r++) m_rows[r] = rand_row(int'($urandom_range(0, 2)));
    endtask

    task automatic model_clear();
        logic [RW-1:0] kept [$];
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!full_row(m_rows[r])) kept.push_back(m_rows[r]);
        end
        m_lines = ROWS - kept.size();
        for (int r = ROWS - 1; r >= 0; r--) begin
            int k;
            k = ROWS - 1 - r;
            m_rows[r] = (k < kept.size()) ? kept[k] : '0;
        end
    endtask

    task automatic load_model();
        PixelMapIn = m_flat();
        LoadAll = 1'b1;
        tick();
        LoadAll = 1'b0;
    endtask

    task automatic run_clear(output int busy_n, output logic done_end, output logic done_next);
        ClearStart = 1'b1;
        tick();
        ClearStart = 1'b0;
        busy_n = 0;
        while (Busy === 1'b1 && busy_n < 400) begin
            busy_n++;
            tick();
        end
        done_end = Done;
        tick();
        done_next = Done;
    endtask

    task automatic test_reset();
        tick();
        tick();
        Reset = 1'b0;
        m_clear_rows();
        checks++;
        if (BoardOut !== '0 || RowFull !== '0) begin
            errors++;
            $display("FAIL reset_board: board %h rowfull %h required zero", BoardOut, RowFull);
        end
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || LinesCleared !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy %b done %b lines %0d required 0 0 0", Busy, Done, LinesCleared);
        end
        Reset = 1'b1;
        ClearStart = 1'b1;
        tick();
        Reset = 1'b0;
        ClearStart = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_clear: busy %b required 0", Busy);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_clear_idle: busy %b done %b required 0 0", Busy, Done);
        end
    endtask

    task automatic test_load_priority();
        LoadRow = 1'b1;
        RowSel = IDX_W'(5);
        RowIn = fill_row(4'h3);
        tick();
        LoadRow = 1'b0;
        m_rows[5] = fill_row(4'h3);
        checks++;
        if (BoardOut !== m_flat() || RowFull !== ROWS'(1 << 5)) begin
            errors++;
            $display("FAIL load_row5: board %h rowfull %h required %h %h", BoardOut, RowFull, m_flat(), ROWS'(1 << 5));
        end
        LoadAll = 1'b1;
        PixelMapIn = '0;
        LoadRow = 1'b1;
        RowSel = IDX_W'(7);
        ClearStart = 1'b1;
        tick();
        LoadAll = 1'b0;
        LoadRow = 1'b0;
        m_clear_rows();
        checks++;
        if (BoardOut !== '0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL loadall_wins: board %h busy %b required zero 0", BoardOut, Busy);
        end
        LoadRow = 1'b1;
        RowSel = IDX_W'(2);
        RowIn = fill_row(4'h9);
        tick();
        LoadRow = 1'b0;
        ClearStart = 1'b0;
        m_rows[2] = fill_row(4'h9);
        checks++;
        if (BoardOut !== m_flat() || Busy !== 1'b0) begin
            errors++;
            $display("FAIL loadrow_beats_clear: board %h busy %b required %h 0", BoardOut, Busy, m_flat());
        end
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 60; i++) begin
            int sel;
            logic la, lr;
            la = ($urandom_range(0, 3) == 0);
            lr = ($urandom_range(0, 1) == 1);
            sel = int'($urandom_range(0, 31));
            for (int r = 0; r < ROWS; r++) PixelMapIn[r*RW +: RW] = rand_row(int'($urandom_range(0, 2)));
            RowIn = rand_row(int'($urandom_range(1, 2)));
            RowSel = IDX_W'(sel);
            LoadAll = la;
            LoadRow = lr;
            tick();
            if (la) begin
                for (int r = 0; r < ROWS; r++) m_rows[r] = PixelMapIn[r*RW +: RW];
            end else if (lr && sel < ROWS) begin
                m_rows[sel] = RowIn;
            end
            checks++;
            if (BoardOut !== m_flat() || RowFull !== m_full()) begin
                errors++;
                $display("FAIL rand_load[%0d]: board %h rowfull %h required %h %h", i, BoardOut, RowFull, m_flat(), m_full());
            end
        end
        LoadAll = 1'b0;
        LoadRow = 1'b0;
    endtask

    task automatic test_clear_directed();
        int   exp_lines [5] = '{0, 2, 2, 1, 20};
        int   exp_busy  [5] = '{20, 24, 24, 22, 60};
        int   busy_n;
        logic d_end, d_next;
        for (int s = 0; s < 5; s++) begin
            m_clear_rows();
            case (s)
                1: begin
                    m_rows[19] = fill_row(4'h1);
                    m_rows[18] = fill_row(4'h1);
                    m_rows[17][PIX_W-1:0] = 4'h2;
                end
                2: begin
                    m_rows[19] = fill_row(4'h1);
                    m_rows[17] = fill_row(4'h1);
                    for (int c = 0; c < 5; c++) m_rows[18][c*PIX_W +: PIX_W] = 4'h5;
                end
                3: m_rows[0] = fill_row(4'h7);
                4: for (int r = 0; r < ROWS; r++) m_rows[r] = rand_row(1);
                default: ;
            endcase
            load_model();
            run_clear(busy_n, d_end, d_next);
            model_clear();
            checks++;
            if (busy_n !== exp_busy[s]) begin
                errors++;
                $display("FAIL clear_busy[%0d]: busy cycles %0d required %0d", s, busy_n, exp_busy[s]);
            end
            checks++;
            if (d_end !== 1'b1 || d_next !== 1'b0) begin
                errors++;
                $display("FAIL clear_done[%0d]: done %b then %b required 1 then 0", s, d_end, d_next);
            end
            checks++;
            if (LinesCleared !== CNT_W'(exp_lines[s])) begin
                errors++;
                $display("FAIL clear_lines[%0d]: lines %0d required %0d", s, LinesCleared, exp_lines[s]);
            end
            checks++;
            if (BoardOut !== m_flat()) begin
                errors++;
                $display("FAIL clear_board[%0d]: board %h required %h", s, BoardOut, m_flat());
            end
        end
        m_clear_rows();
        load_model();
        tick();
        checks++;
        if (LinesCleared !== CNT_W'(ROWS)) begin
            errors++;
            $display("FAIL lines_hold: lines %0d required %0d", LinesCleared, ROWS);
        end
    endtask

    task automatic test_clear_random();
        int   busy_n;
        logic d_end, d_next;
        for (int i = 0; i < 8; i++) begin
            m_random_board();
            load_model();
            run_clear(busy_n, d_end, d_next);
            model_clear();
            checks++;
            if (busy_n !== ROWS + 2 * m_lines || d_end !== 1'b1 || d_next !== 1'b0) begin
                errors++;
                $display("FAIL rand_clear_timing[%0d]: busy %0d done %b/%b required %0d 1/0", i, busy_n, d_end, d_next, ROWS + 2 * m_lines);
            end
            checks++;
            if (LinesCleared !== CNT_W'(m_lines) || BoardOut !== m_flat()) begin
                errors++;
                $display("FAIL rand_clear_result[%0d]: lines %0d board %h required %0d %h", i, LinesCleared, BoardOut, m_lines, m_flat());
            end
        end
    endtask

    task automatic test_reset_mid();
        int busy_seen, done_seen;
        m_random_board();
        m_rows[19] = fill_row(4'h4);
        m_rows[10] = fill_row(4'h6);
        load_model();
        ClearStart = 1'b1;
        tick();
        ClearStart = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_clear_rows();
        checks++;
        if (BoardOut !== '0 || Busy !== 1'b0 || Done !== 1'b0 || LinesCleared !== '0) begin
            errors++;
            $display("FAIL reset_mid: board %h busy %b done %b lines %0d required zero 0 0 0", BoardOut, Busy, Done, LinesCleared);
        end
        busy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (Busy !== 1'b0) busy_seen++;
            if (Done !== 1'b0) done_seen++;
            tick();
        end
        checks++;
        if (busy_seen != 0 || done_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: busy cycles %0d done cycles %0d required 0 0", busy_seen, done_seen);
        end
    endtask

    task automatic test_loadall_busy();
        int   n;
        logic d_end;
        m_random_board();
        m_rows[19] = fill_row(4'h2);
        m_rows[3]  = fill_row(4'hA);
        load_model();
        ClearStart = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < ROWS; r++) PixelMapIn[r*RW +: RW] = rand_row(1);
            LoadAll = 1'b1;
            LoadRow = 1'b1;
            RowSel = IDX_W'(19);
            RowIn = rand_row(1);
            tick();
        end
        LoadAll = 1'b0;
        LoadRow = 1'b0;
        ClearStart = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        d_end = Done;
        model_clear();
        checks++;
        if (n >= 400 || d_end !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore_end: waited %0d done %b required <400 1", n, d_end);
        end
        checks++;
        if (LinesCleared !== CNT_W'(m_lines) || BoardOut !== m_flat()) begin
            errors++;
            $display("FAIL busy_ignore_result: lines %0d board %h required %0d %h", LinesCleared, BoardOut, m_lines, m_flat());
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: busy %b done %b required 0 0", Busy, Done);
        end
    endtask

    initial begin
        test_reset();
        test_load_priority();
        test_random_loads();
        test_clear_directed();
        test_clear_random();
        test_reset_mid();
        test_loadall_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
